// File: rtl/fifo_frame_packer_pkg.sv
// Shared definitions for the FIFO frame packer: FSM state encoding and parameter defaults.
package fifo_frame_packer_pkg;

    localparam int         DEF_DATA_W    = 8;
    localparam int         DEF_FRAME_LEN = 4;
    localparam logic [7:0] DEF_SOF_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CKSUM   = 2'd3
    } state_t;

endpackage

// File: rtl/frame_xor_accum.sv
// Running XOR of payload bytes; clear has priority over enable.
import fifo_frame_packer_pkg::*;

module frame_xor_accum #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg ^ din;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/fifo_frame_packer.sv
// Reads FRAME_LEN bytes from an upstream FIFO and emits header, payload and XOR checksum
// over a valid/ready byte stream. All outputs are registered.
module fifo_frame_packer
    import fifo_frame_packer_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                FRAME_LEN = DEF_FRAME_LEN,
    parameter logic [DATA_W-1:0] SOF_BYTE  = DATA_W'(DEF_SOF_BYTE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              rd_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              busy,
    output logic [7:0]        frame_count
);

    localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);

    state_t            state_reg, state_next;
    logic [7:0]        req_cnt_reg, req_cnt_next;
    logic              rd_en_reg, rd_en_next;
    logic              rd_dly_reg;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic              tx_valid_reg, tx_valid_next;
    logic              tx_sof_reg, tx_sof_next;
    logic              tx_eof_reg, tx_eof_next;
    logic              busy_reg;
    logic [7:0]        frame_count_reg, frame_count_next;
    logic [DATA_W-1:0] acc_value;
    logic              acc_clr;
    logic              hs;
    logic              slot_free;
    logic              last_hs;

    // A read issued while the previous byte is still on the output can land while that
    // byte is stalled; the one-entry skid register catches it so tx_data never changes early.
    assign hs        = tx_valid_reg && tx_ready;
    assign slot_free = !tx_valid_reg || hs;
    assign last_hs   = hs && (req_cnt_reg == FRAME_LEN_C) && !rd_en_reg
                       && !rd_dly_reg && !skid_valid_reg;

    frame_xor_accum #(
        .DATA_W (DATA_W)
    ) u_accum (
        .clk (clk),
        .rst (rst),
        .en  (rd_dly_reg),
        .clr (acc_clr),
        .din (fifo_data),
        .acc (acc_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            req_cnt_reg     <= '0;
            rd_en_reg       <= 1'b0;
            rd_dly_reg      <= 1'b0;
            skid_reg        <= '0;
            skid_valid_reg  <= 1'b0;
            tx_data_reg     <= '0;
            tx_valid_reg    <= 1'b0;
            tx_sof_reg      <= 1'b0;
            tx_eof_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            req_cnt_reg     <= req_cnt_next;
            rd_en_reg       <= rd_en_next;
            rd_dly_reg      <= rd_en_reg;
            skid_reg        <= skid_next;
            skid_valid_reg  <= skid_valid_next;
            tx_data_reg     <= tx_data_next;
            tx_valid_reg    <= tx_valid_next;
            tx_sof_reg      <= tx_sof_next;
            tx_eof_reg      <= tx_eof_next;
            busy_reg        <= (state_next != ST_IDLE);
            frame_count_reg <= frame_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        req_cnt_next     = req_cnt_reg;
        rd_en_next       = 1'b0;
        skid_next        = skid_reg;
        skid_valid_next  = skid_valid_reg;
        tx_data_next     = tx_data_reg;
        tx_valid_next    = tx_valid_reg;
        tx_sof_next      = tx_sof_reg;
        tx_eof_next      = tx_eof_reg;
        frame_count_next = frame_count_reg;
        acc_clr          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!buf_empty) begin
                    state_next    = ST_HDR;
                    tx_data_next  = SOF_BYTE;
                    tx_valid_next = 1'b1;
                    tx_sof_next   = 1'b1;
                end
            end

            ST_HDR: begin
                if (hs) begin
                    state_next    = ST_PAYLOAD;
                    tx_data_next  = '0;
                    tx_valid_next = 1'b0;
                    tx_sof_next   = 1'b0;
                end
            end

            ST_PAYLOAD: begin
                if (rd_en_reg) begin
                    req_cnt_next = req_cnt_reg + 8'd1;
                end
                if (last_hs) begin
                    state_next    = ST_CKSUM;
                    tx_data_next  = acc_value;
                    tx_valid_next = 1'b1;
                    tx_eof_next   = 1'b1;
                end else begin
                    if (slot_free) begin
                        if (skid_valid_reg) begin
                            tx_data_next    = skid_reg;
                            tx_valid_next   = 1'b1;
                            skid_valid_next = 1'b0;
                        end else if (rd_dly_reg) begin
                            tx_data_next  = fifo_data;
                            tx_valid_next = 1'b1;
                        end else begin
                            tx_valid_next = 1'b0;
                        end
                    end
                    if (rd_dly_reg && !(slot_free && !skid_valid_reg)) begin
                        skid_next       = fifo_data;
                        skid_valid_next = 1'b1;
                    end
                    rd_en_next = (req_cnt_reg < FRAME_LEN_C) && !buf_empty
                                 && !rd_en_reg && slot_free;
                end
            end

            ST_CKSUM: begin
                if (hs) begin
                    state_next       = ST_IDLE;
                    tx_data_next     = '0;
                    tx_valid_next    = 1'b0;
                    tx_eof_next      = 1'b0;
                    frame_count_next = frame_count_reg + 8'd1;
                    req_cnt_next     = '0;
                    acc_clr          = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rd_en       = rd_en_reg;
    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign tx_sof      = tx_sof_reg;
    assign tx_eof      = tx_eof_reg;
    assign busy        = busy_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Self-checking bench for fifo_frame_packer: FIFO model upstream, frame-level reference model
// downstream, directed scenarios plus randomized data and back-pressure.
module tb_fifo_frame_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       buf_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       rd_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_sof;
    logic       tx_eof;
    logic       busy;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    fifo_frame_packer dut (
        .clk         (clk),
        .rst         (rst),
        .buf_empty   (buf_empty),
        .fifo_data   (fifo_data),
        .rd_en       (rd_en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .busy        (busy),
        .frame_count (frame_count)
    );

    // Upstream FIFO model: data appears on fifo_data the cycle after rd_en.
    logic [7:0] fifo_mem [0:4095];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign buf_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en && !buf_empty) begin
            fifo_data <= fifo_mem[rd_ptr[11:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[11:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Downstream monitor
    logic [7:0] cap_data[$];
    logic       cap_sof[$];
    logic       cap_eof[$];
    int         rd_cnt = 0;
    int         eof_cnt = 0;
    int         rd_empty_err = 0;
    int         hold_err = 0;
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            cap_data.push_back(tx_data);
            cap_sof.push_back(tx_sof);
            cap_eof.push_back(tx_eof);
            if (tx_eof) begin
                eof_cnt <= eof_cnt + 1;
                $display("frame %0d complete: checksum %02h frame_count_before %0d",
                         eof_cnt + 1, tx_data, frame_count);
            end
        end
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (rd_en && buf_empty) rd_empty_err <= rd_empty_err + 1;
        if (rst && hold_pending && (!tx_valid || tx_data !== hold_data))
            hold_err <= hold_err + 1;
        hold_pending <= rst && tx_valid && !tx_ready;
        hold_data    <= tx_data;
    end

    // Reference model: a frame is SOF, the payload bytes, then their XOR.
    int         n_checks = 0;
    int         n_fail = 0;
    int         model_frames = 0;
    logic [7:0] pay_q[$];
    logic [7:0] exp_data[$];
    logic       exp_sof[$];
    logic       exp_eof[$];

    task automatic clear_model();
        exp_data.delete();
        exp_sof.delete();
        exp_eof.delete();
        pay_q.delete();
    endtask

    task automatic model_frame(input int n);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_data.push_back(8'hA5); exp_sof.push_back(1'b1); exp_eof.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            b = pay_q.pop_front();
            x = x ^ b;
            exp_data.push_back(b); exp_sof.push_back(1'b0); exp_eof.push_back(1'b0);
        end
        exp_data.push_back(x); exp_sof.push_back(1'b0); exp_eof.push_back(1'b1);
        model_frames = model_frames + 1;
    endtask

    task automatic wait_eof(input int target, input int limit);
        for (int t = 0; t < limit && eof_cnt < target; t++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_frames = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_en, tx_valid, tx_sof, tx_eof, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %05b, expected 00000", {rd_en, tx_valid, tx_sof, tx_eof, busy});
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_tx_data: got %02h, expected 00", tx_data);
        end
        n_checks++;
        if (frame_count !== 8'h00) begin
            n_fail++; $display("FAIL reset_frame_count: got %0d, expected 0", frame_count);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, rd_en, tx_valid} !== 3'b000) begin
            n_fail++; $display("FAIL idle_when_empty: got busy/rd_en/valid %03b, expected 000", {busy, rd_en, tx_valid});
        end
    endtask

    task automatic test_basic();
        int c0, r0, f0;
        clear_model();
        c0 = cap_data.size(); r0 = rd_cnt; f0 = eof_cnt;
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(8'(i)); pay_q.push_back(8'(i));
        end
        model_frame(4);
        wait_eof(f0 + 1, 300);
        n_checks++;
        if (eof_cnt !== f0 + 1) begin
            n_fail++; $display("FAIL basic_timeout: got %0d frames, expected %0d", eof_cnt - f0, 1);
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (c0 + i >= cap_data.size()) begin
                n_fail++; $display("FAIL basic_byte[%0d]: got none, expected %02h", i, exp_data[i]);
            end else if ({cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
                n_fail++;
                $display("FAIL basic_byte[%0d]: got %02h sof=%0b eof=%0b, expected %02h sof=%0b eof=%0b", i,
                         cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i], exp_data[i], exp_sof[i], exp_eof[i]);
            end
        end
        n_checks++;
        if (frame_count !== model_frames[7:0]) begin
            n_fail++; $display("FAIL basic_frame_count: got %0d, expected %0d", frame_count, model_frames[7:0]);
        end
        n_checks++;
        if (rd_cnt - r0 !== 4) begin
            n_fail++; $display("FAIL basic_rd_pulses: got %0d, expected 4", rd_cnt - r0);
        end
    endtask

    task automatic test_stall();
        int c0, r0, f0;
        bit stalled;
        clear_model();
        c0 = cap_data.size(); r0 = rd_cnt; f0 = eof_cnt;
        stalled = 1'b0;
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(8'(i)); pay_q.push_back(8'(i));
        end
        model_frame(4);
        for (int t = 0; t < 300 && eof_cnt < f0 + 1; t++) begin
            @(negedge clk);
            if (!stalled && tx_valid && !tx_sof && tx_data === 8'h02) begin
                stalled = 1'b1;
                tx_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (tx_valid !== 1'b1 || tx_data !== 8'h02 || rd_en !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: got valid=%0b data=%02h rd_en=%0b, expected valid=1 data=02 rd_en=0",
                                 k, tx_valid, tx_data, rd_en);
                    end
                end
                tx_ready = 1'b1;
            end
        end
        n_checks++;
        if (!stalled || eof_cnt !== f0 + 1) begin
            n_fail++; $display("FAIL stall_progress: got stalled=%0b frames=%0d, expected 1 and 1", stalled, eof_cnt - f0);
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (c0 + i >= cap_data.size()) begin
                n_fail++; $display("FAIL stall_byte[%0d]: got none, expected %02h", i, exp_data[i]);
            end else if ({cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
                n_fail++;
                $display("FAIL stall_byte[%0d]: got %02h sof=%0b eof=%0b, expected %02h sof=%0b eof=%0b", i,
                         cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i], exp_data[i], exp_sof[i], exp_eof[i]);
            end
        end
        n_checks++;
        if (rd_cnt - r0 !== 4 || hold_err !== 0) begin
            n_fail++; $display("FAIL stall_reads_hold: got reads=%0d hold_err=%0d, expected 4 and 0", rd_cnt - r0, hold_err);
        end
    endtask

    task automatic test_fifo_empty();
        int c0, r0, f0;
        clear_model();
        c0 = cap_data.size(); r0 = rd_cnt; f0 = eof_cnt;
        tx_ready = 1'b1;
        push(8'h01); push(8'h02);
        repeat (30) @(negedge clk);
        n_checks++;
        if (rd_cnt - r0 !== 2 || tx_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_hold: got reads=%0d valid=%0b busy=%0b, expected 2 0 1", rd_cnt - r0, tx_valid, busy);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_cnt - r0 !== 2 || rd_empty_err !== 0) begin
            n_fail++; $display("FAIL empty_no_read: got reads=%0d rd_empty_err=%0d, expected 2 and 0", rd_cnt - r0, rd_empty_err);
        end
        push(8'h03); push(8'h04);
        for (int i = 1; i <= 4; i++) pay_q.push_back(8'(i));
        model_frame(4);
        wait_eof(f0 + 1, 300);
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (c0 + i >= cap_data.size()) begin
                n_fail++; $display("FAIL empty_byte[%0d]: got none, expected %02h", i, exp_data[i]);
            end else if ({cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
                n_fail++;
                $display("FAIL empty_byte[%0d]: got %02h sof=%0b eof=%0b, expected %02h sof=%0b eof=%0b", i,
                         cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i], exp_data[i], exp_sof[i], exp_eof[i]);
            end
        end
        n_checks++;
        if (frame_count !== model_frames[7:0]) begin
            n_fail++; $display("FAIL empty_frame_count: got %0d, expected %0d", frame_count, model_frames[7:0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0, c1, f0;
        clear_model();
        c0 = cap_data.size();
        tx_ready = 1'b1;
        push(8'h01); push(8'h02);
        for (int t = 0; t < 200 && cap_data.size() < c0 + 3; t++) @(negedge clk);
        n_checks++;
        if (cap_data.size() < c0 + 3) begin
            n_fail++; $display("FAIL midrst_prefix: got %0d bytes, expected 3", cap_data.size() - c0);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rd_en, tx_valid, tx_sof, tx_eof, busy} !== 5'b0 || tx_data !== 8'h00 || frame_count !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: got flags=%05b data=%02h count=%0d, expected all zero",
                     {rd_en, tx_valid, tx_sof, tx_eof, busy}, tx_data, frame_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_frames = 0;
        c1 = cap_data.size(); f0 = eof_cnt;
        for (int i = 5; i <= 8; i++) begin
            push(8'(i)); pay_q.push_back(8'(i));
        end
        model_frame(4);
        wait_eof(f0 + 1, 300);
        n_checks++;
        if (c1 !== c0 + 3) begin
            n_fail++; $display("FAIL midrst_no_cksum: got %0d bytes before reset, expected 3", c1 - c0);
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (c1 + i >= cap_data.size()) begin
                n_fail++; $display("FAIL midrst_byte[%0d]: got none, expected %02h", i, exp_data[i]);
            end else if ({cap_data[c1+i], cap_sof[c1+i], cap_eof[c1+i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
                n_fail++;
                $display("FAIL midrst_byte[%0d]: got %02h sof=%0b eof=%0b, expected %02h sof=%0b eof=%0b", i,
                         cap_data[c1+i], cap_sof[c1+i], cap_eof[c1+i], exp_data[i], exp_sof[i], exp_eof[i]);
            end
        end
        n_checks++;
        if (frame_count !== 8'd1) begin
            n_fail++; $display("FAIL midrst_frame_count: got %0d, expected 1", frame_count);
        end
    endtask

    task automatic test_random();
        int c0, r0, f0, pushed;
        logic [7:0] rb[$];
        clear_model();
        c0 = cap_data.size(); r0 = rd_cnt; f0 = eof_cnt;
        for (int i = 0; i < 80; i++) begin
            rb.push_back(8'($urandom_range(0, 255)));
            pay_q.push_back(rb[i]);
        end
        for (int f = 0; f < 20; f++) model_frame(4);
        pushed = 0;
        for (int t = 0; t < 5000 && eof_cnt < f0 + 20; t++) begin
            @(negedge clk);
            tx_ready = ($urandom_range(0, 3) != 0);
            if (pushed < 80 && $urandom_range(0, 1) == 1) begin
                push(rb[pushed]);
                pushed++;
            end
        end
        tx_ready = 1'b1;
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (c0 + i >= cap_data.size()) begin
                n_fail++; $display("FAIL random_byte[%0d]: got none, expected %02h", i, exp_data[i]);
            end else if ({cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
                n_fail++;
                $display("FAIL random_byte[%0d]: got %02h sof=%0b eof=%0b, expected %02h sof=%0b eof=%0b", i,
                         cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i], exp_data[i], exp_sof[i], exp_eof[i]);
            end
        end
        n_checks++;
        if (hold_err !== 0 || rd_empty_err !== 0 || rd_cnt - r0 !== 80) begin
            n_fail++;
            $display("FAIL random_protocol: got hold_err=%0d rd_empty_err=%0d reads=%0d, expected 0 0 80",
                     hold_err, rd_empty_err, rd_cnt - r0);
        end
        n_checks++;
        if (frame_count !== model_frames[7:0]) begin
            n_fail++; $display("FAIL random_frame_count: got %0d, expected %0d", frame_count, model_frames[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        int c0, f0, idle_cycles;
        bit started;
        do_reset();
        clear_model();
        c0 = cap_data.size(); f0 = eof_cnt;
        tx_ready = 1'b1;
        for (int i = 0; i < 257 * 4; i++) begin
            push(8'h00); pay_q.push_back(8'h00);
        end
        for (int f = 0; f < 257; f++) model_frame(4);
        idle_cycles = 0;
        started = 1'b0;
        for (int t = 0; t < 8000 && eof_cnt < f0 + 257; t++) begin
            @(negedge clk);
            if (eof_cnt >= f0 + 257) break;
            if (busy) started = 1'b1;
            else if (started) idle_cycles++;
        end
        n_checks++;
        if (eof_cnt !== f0 + 257) begin
            n_fail++; $display("FAIL b2b_timeout: got %0d frames, expected 257", eof_cnt - f0);
        end
        n_checks++;
        if (idle_cycles !== 256) begin
            n_fail++; $display("FAIL b2b_idle_gap: got %0d idle cycles, expected 256", idle_cycles);
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (c0 + i >= cap_data.size()) begin
                n_fail++; $display("FAIL b2b_byte[%0d]: got none, expected %02h", i, exp_data[i]);
            end else if ({cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i]} !== {exp_data[i], exp_sof[i], exp_eof[i]}) begin
                n_fail++;
                $display("FAIL b2b_byte[%0d]: got %02h sof=%0b eof=%0b, expected %02h sof=%0b eof=%0b", i,
                         cap_data[c0+i], cap_sof[c0+i], cap_eof[c0+i], exp_data[i], exp_sof[i], exp_eof[i]);
            end
        end
        n_checks++;
        if (frame_count !== model_frames[7:0]) begin
            n_fail++; $display("FAIL b2b_frame_count: got %0d, expected %0d", frame_count, model_frames[7:0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_fifo_empty();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
